rank_accumulator: RTL and testbench
===================================

Name: rank_accumulator

Overview:
Downstream consumer of the per-node contribution register file. On a start pulse it sweeps every regfile address through the registered read port (readEnable/source → dataOut, 1-cycle latency). It sums the contribution fields of valid entries and applies the damping step. The new rank value is presented on a valid/ready output to the rank-update/NoC injection stage.

Parameters:
WIDTH, 16, regfile word width; bit 0 = valid flag, bits [WIDTH-1:1] = unsigned contribution
ADDWIDTH, 4, regfile address width; DEPTH = 2**ADDWIDTH entries swept
RANKW, 16, output rank width
DAMP_NUM, 217, damping numerator (0.85 in Q8)
DAMP_SHIFT, 8, damping right-shift
BASE, 38, additive teleport term (0.15/N in output fixed-point)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse, begin sweep; ignored unless IDLE
busy  output  1  high in any state other than IDLE
rf_read_enable  output  1  to regfile readEnable
rf_source  output  ADDWIDTH  to regfile source
rf_data  input  WIDTH  from regfile dataOut (registered, valid the cycle after the request)
rank_out  output  RANKW  computed rank
rank_valid  output  1  rank_out valid
rank_ready  input  1  consumer accepts when rank_valid && rank_ready
valid_count  output  ADDWIDTH+1  number of valid entries seen in the last sweep; stable while rank_valid

Behaviour:
- Reset (async, any state): state=IDLE; busy, rf_read_enable, rank_valid = 0; rf_source, rank_out, valid_count, accumulator, address counter = 0.
- States: IDLE, SCAN, DRAIN, CALC, OUT.
- IDLE: outputs idle. Start sampled high at edge E0 → SCAN. Clear accumulator and count on entry.
- SCAN, cycle k (k=0..DEPTH-1 after E0):
  - rf_read_enable=1, rf_source=k.
  - Data requested in cycle k-1 arrives on rf_data in cycle k and is accumulated at the end of cycle k (capture pipeline flag delayed one cycle).
  - After address DEPTH-1 is issued → DRAIN; no address wrap-around re-issue.
- DRAIN: rf_read_enable=0; accumulate the last entry (address DEPTH-1) → CALC.
- Accumulate rule:
  - If rf_data[0]==1: acc += rf_data[WIDTH-1:1] and count += 1.
  - Else skip; no change.
  - acc width = WIDTH-1+ADDWIDTH, which cannot overflow.
- CALC:
  - prod = acc*DAMP_NUM at full width; res = (prod >> DAMP_SHIFT) + BASE.
  - If res > 2**RANKW-1, rank_out = all ones (saturate); else rank_out = res.
  - Register rank_out and valid_count → OUT.
- OUT: rank_valid=1; rank_out and valid_count held stable until rank_valid && rank_ready, then → IDLE, with rank_valid low next cycle.
- Latency: with rank_ready tied high, rank_valid is first high DEPTH+3 cycles after E0 and the block is IDLE DEPTH+4 cycles after E0.
- start during SCAN/DRAIN/CALC/OUT: ignored, never queued.
- start in the same cycle as the OUT handshake: ignored; a new start is needed once IDLE.
- Regfile writes during a sweep: whatever value the regfile returns is used; no coherency guarantee.
- Reset mid-sweep: immediate return to IDLE, partial sum discarded, no rank_valid pulse.

Test Plan:
- All entries 0 (post-reset regfile): start → rank_valid at cycle DEPTH+3, rank_out=38, valid_count=0; rf_source sequences 0..15 with rf_read_enable high exactly 16 cycles.
- Entry 3 = (100<<1)|1, entry 7 = (200<<1)|1, others 0: sum 300 → rank_out=(65100>>8)+38=292, valid_count=2.
- All 16 entries = 0xFFFF (contribution 32767): sum 524272 → (113767024>>8)+38 exceeds 65535 → rank_out=65535 (saturated), valid_count=16.
- Backpressure: hold rank_ready=0 for 10 cycles in OUT → rank_valid, rank_out, valid_count stable; start pulses during this window are ignored; release → one handshake, then IDLE.
- Reset asserted at SCAN cycle 5: all outputs 0 immediately. A fresh start with entry 3 valid still loaded yields rank_out=292 only if entry 7 also remains valid; the partial sum from the aborted sweep must not carry over.
- Back-to-back: start immediately after IDLE re-entry → second sweep produces an identical result and timing.

Source files
------------

// File: rtl/rank_accumulator.sv
// Sweeps the contribution register file, sums the valid entries and applies the
// damping step; the damped rank is offered on a valid/ready output.
module rank_accumulator #(
  parameter int WIDTH      = 16,
  parameter int ADDWIDTH   = 4,
  parameter int RANKW      = 16,
  parameter int DAMP_NUM   = 217,
  parameter int DAMP_SHIFT = 8,
  parameter int BASE       = 38
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                rf_read_enable,
  output logic [ADDWIDTH-1:0] rf_source,
  input  logic [WIDTH-1:0]    rf_data,
  output logic [RANKW-1:0]    rank_out,
  output logic                rank_valid,
  input  logic                rank_ready,
  output logic [ADDWIDTH:0]   valid_count
);

  localparam int DEPTH = 2 ** ADDWIDTH;
  localparam int CONTW = WIDTH - 1;
  localparam int ACCW  = CONTW + ADDWIDTH;
  localparam int NUMW  = $clog2(DAMP_NUM + 1);
  localparam int PRODW = ACCW + NUMW;
  localparam int RESW  = PRODW + 1;

  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, CALC, OUT} state_t;

  state_t              state_q, state_d;
  logic [ADDWIDTH-1:0] addr_q, addr_d;
  logic [ACCW-1:0]     acc_q, acc_d;
  logic [ADDWIDTH:0]   cnt_q, cnt_d;
  logic [RANKW-1:0]    rank_q, rank_d;
  logic [ADDWIDTH:0]   vcnt_q, vcnt_d;
  logic                cap_q;

  function automatic logic [RANKW-1:0] damp_sat(input logic [ACCW-1:0] acc);
    logic [PRODW-1:0] prod;
    logic [RESW-1:0]  res;
    prod = PRODW'(acc) * PRODW'(DAMP_NUM);
    res  = RESW'(prod >> DAMP_SHIFT) + RESW'(BASE);
    if ((res >> RANKW) != '0) damp_sat = {RANKW{1'b1}};
    else                      damp_sat = res[RANKW-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    rank_d  = rank_q;
    vcnt_d  = vcnt_q;
    // cap_q marks the cycle in which the word requested one cycle earlier is on rf_data
    if (cap_q && rf_data[0]) begin
      acc_d = acc_q + ACCW'(rf_data[WIDTH-1:1]);
      cnt_d = cnt_q + {{ADDWIDTH{1'b0}}, 1'b1};
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          addr_d  = '0;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        if (addr_q == ADDWIDTH'(DEPTH - 1)) begin
          state_d = DRAIN;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDWIDTH'(1);
        end
      end
      DRAIN: state_d = CALC;
      CALC: begin
        rank_d  = damp_sat(acc_q);
        vcnt_d  = cnt_q;
        state_d = OUT;
      end
      OUT: begin
        if (rank_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      rank_q  <= '0;
      vcnt_q  <= '0;
      cap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rank_q  <= rank_d;
      vcnt_q  <= vcnt_d;
      cap_q   <= (state_q == SCAN);
    end
  end

  assign busy           = (state_q != IDLE);
  assign rf_read_enable = (state_q == SCAN);
  assign rf_source      = addr_q;
  assign rank_valid     = (state_q == OUT);
  assign rank_out       = rank_q;
  assign valid_count    = vcnt_q;

endmodule

// File: tb/tb_rank_accumulator.sv
// Bench for rank_accumulator: regfile model, timeline/arithmetic reference model,
// per-cycle output comparison and directed scenarios with literal expectations.
module tb_rank_accumulator;
  localparam int WIDTH    = 16;
  localparam int ADDWIDTH = 4;
  localparam int RANKW    = 16;
  localparam int DEPTH    = 16;

  logic                clk = 1'b0;
  logic                reset, start, rank_ready;
  logic                busy, rf_read_enable, rank_valid;
  logic [ADDWIDTH-1:0] rf_source;
  logic [WIDTH-1:0]    rf_data;
  logic [RANKW-1:0]    rank_out;
  logic [ADDWIDTH:0]   valid_count;

  int pass_cnt = 0;
  int total    = 0;

  logic [WIDTH-1:0] mem [DEPTH];

  always #5 clk = ~clk;

  rank_accumulator #(
    .WIDTH(WIDTH), .ADDWIDTH(ADDWIDTH), .RANKW(RANKW),
    .DAMP_NUM(217), .DAMP_SHIFT(8), .BASE(38)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .rf_read_enable(rf_read_enable), .rf_source(rf_source), .rf_data(rf_data),
    .rank_out(rank_out), .rank_valid(rank_valid), .rank_ready(rank_ready),
    .valid_count(valid_count)
  );

  // Register file with a registered read port
  always @(posedge clk or posedge reset) begin
    if (reset) rf_data <= '0;
    else if (rf_read_enable) rf_data <= mem[rf_source];
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic longint model_rank();
    longint sum = 0;
    for (int i = 0; i < DEPTH; i++)
      if (mem[i][0]) sum += longint'(mem[i][WIDTH-1:1]);
    sum = (sum * 217) / 256 + 38;
    if (sum > 65535) sum = 65535;
    return sum;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i][0]) c++;
    return c;
  endfunction

  // Timeline: t counts cycles since the accepting edge; outputs follow fixed latencies
  bit     active = 1'b0;
  int     t = 0;
  longint exp_rank = 0;
  int     exp_cnt = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      active <= 1'b0;
      t      <= 0;
    end else if (!active) begin
      if (start) begin
        active   <= 1'b1;
        t        <= 0;
        exp_rank <= model_rank();
        exp_cnt  <= model_count();
      end
    end else if (t >= DEPTH + 2 && rank_ready) begin
      active <= 1'b0;
    end else begin
      t <= t + 1;
    end
  end

  always @(negedge clk) begin
    if (!active) begin
      check("idle_busy", busy, 0);
      check("idle_rden", rf_read_enable, 0);
      check("idle_valid", rank_valid, 0);
    end else if (t < DEPTH) begin
      check("scan_busy", busy, 1);
      check("scan_rden", rf_read_enable, 1);
      check("scan_src", rf_source, t);
      check("scan_valid", rank_valid, 0);
    end else if (t < DEPTH + 2) begin
      check("tail_busy", busy, 1);
      check("tail_rden", rf_read_enable, 0);
      check("tail_valid", rank_valid, 0);
    end else begin
      check("out_busy", busy, 1);
      check("out_valid", rank_valid, 1);
      check("out_rank", rank_out, exp_rank);
      check("out_count", valid_count, exp_cnt);
    end
  end

  task automatic sweep(output int lat_v, output int lat_i, output int rden,
                       output logic [RANKW-1:0] r, output logic [ADDWIDTH:0] vc);
    int n = 0;
    lat_v = 0; lat_i = 0; rden = 0; r = '0; vc = '0;
    start = 1'b1;
    while (n < 60 && lat_i == 0) begin
      @(posedge clk); n++; #1;
      start = 1'b0;
      if (rf_read_enable) rden++;
      if (rank_valid && lat_v == 0) begin
        lat_v = n; r = rank_out; vc = valid_count;
      end
      if (!busy) lat_i = n;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rden"}, rf_read_enable, 0);
    check({tag, "_src"}, rf_source, 0);
    check({tag, "_valid"}, rank_valid, 0);
    check({tag, "_rank"}, rank_out, 0);
    check({tag, "_count"}, valid_count, 0);
  endtask

  task automatic load_pair();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    mem[3] = 16'((100 << 1) | 1);
    mem[7] = 16'((200 << 1) | 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lv, li, rd, lv2, li2, rd2;
    logic [RANKW-1:0]  r, r2, held_r;
    logic [ADDWIDTH:0] vc, vc2, held_vc;
    bit seen;

    reset = 1'b1; start = 1'b0; rank_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_all_zero("reset");

    // All entries zero
    check("model_zero", model_rank(), 38);
    @(negedge clk);
    sweep(lv, li, rd, r, vc);
    check("zero_lat_valid", lv, DEPTH + 3);
    check("zero_lat_idle", li, DEPTH + 4);
    check("zero_rden_cycles", rd, 16);
    check("zero_rank", r, 38);
    check("zero_count", vc, 0);

    // Two valid entries
    load_pair();
    check("model_pair", model_rank(), 292);
    @(negedge clk);
    sweep(lv, li, rd, r, vc);
    check("pair_rank", r, 292);
    check("pair_count", vc, 2);
    check("pair_lat_valid", lv, DEPTH + 3);

    // Saturation
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'hFFFF;
    check("model_sat", model_rank(), 65535);
    @(negedge clk);
    sweep(lv, li, rd, r, vc);
    check("sat_rank", r, 65535);
    check("sat_count", vc, 16);

    // Backpressure with start pulses while waiting
    load_pair();
    rank_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (rank_valid) seen = 1'b1;
    end
    check("bp_valid_seen", seen, 1);
    held_r = rank_out; held_vc = valid_count;
    check("bp_rank", held_r, 292);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = (i % 2 == 0);
      check("bp_hold_valid", rank_valid, 1);
      check("bp_hold_rank", rank_out, held_r);
      check("bp_hold_count", valid_count, held_vc);
    end
    @(negedge clk);
    start = 1'b1;
    rank_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("bp_after_valid", rank_valid, 0);
    repeat (3) @(negedge clk);
    check("bp_start_ignored", busy, 0);

    // Reset in SCAN cycle 5, then a fresh sweep
    load_pair();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (active && t == 5) seen = 1'b1;
      else @(negedge clk);
    end
    check("rst_reached_scan5", seen, 1);
    #2 reset = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    sweep(lv, li, rd, r, vc);
    check("rst_rank", r, 292);
    check("rst_count", vc, 2);

    // Back-to-back sweeps
    @(negedge clk);
    sweep(lv, li, rd, r, vc);
    sweep(lv2, li2, rd2, r2, vc2);
    check("b2b_rank", r2, 292);
    check("b2b_same_rank", r2, r);
    check("b2b_count", vc2, 2);
    check("b2b_lat_valid", lv2, DEPTH + 3);
    check("b2b_lat_idle", li2, DEPTH + 4);
    check("b2b_rden", rd2, 16);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
